// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Initiator for a gated SR latch. Turns set / reset / readback commands into
// E and S/R pulses of fixed width, lets the latch settle, then reads q/qb back
// and reports OK, TIMEOUT or ILLEGAL on a one-cycle done strobe. The forbidden
// S=R=1 code is never driven: sr is only ever loaded with 01 or 10.
//
// Parameters
//   PULSE_CYC   : cycles E and S/R stay asserted per write (1..255)
//   SETTLE_CYC  : idle cycles between pulse and readback (1..255)
//   TIMEOUT_CYC : readback samples taken before TIMEOUT is declared (1..255)
//
// Ports
//   clk        in   rising-edge system clock (latch clock domain)
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  driver idle and able to accept a command
//   cmd[1:0]   in   00 readback, 01 reset (R), 10 set (S), 11 illegal
//   E          out  latch enable (registered)
//   sr[1:0]    out  sr[1] = S, sr[0] = R (registered, never 11)
//   q, qb      in   latch true / complementary outputs
//   done       out  one-cycle response strobe (registered)
//   status[1:0]out  00 OK, 01 TIMEOUT, 10 ILLEGAL; held until next done
//   q_cap      out  q sampled when the response was produced
//   dbg_state  out  current FSM state, for checkers
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready depends only on state and rst_n, never on
// cmd_valid. The command is registered at that edge; cmd may change afterwards
// without effect, and cmd_valid while busy is ignored (no queuing).
// -----------------------------------------------------------------------------
module sr_latch_driver #(
   parameter int PULSE_CYC   = 2,
   parameter int SETTLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   output logic       E,
   output logic [1:0] sr,
   input  logic       q,
   input  logic       qb,
   output logic       done,
   output logic [1:0] status,
   output logic       q_cap,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PULSE  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   localparam logic [1:0] CMD_READ  = 2'b00;
   localparam logic [1:0] CMD_RESET = 2'b01;
   localparam logic [1:0] CMD_SET   = 2'b10;
   localparam logic [1:0] CMD_ILL   = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   // Last count value of each timed phase (counters start at 0).
   localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   state_t     state;
   logic [1:0] cmd_r;
   logic [7:0] cnt;
   logic [7:0] cnt_inc;
   logic       match;

   assign cmd_ready = (state == S_IDLE) && rst_n;
   assign dbg_state = state;

   // Saturating increment: the counter never wraps back to zero.
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // Readback expectation for the registered command. q == qb (00 or 11)
   // is never a match for any command.
   always_comb begin
      match = 1'b0;
      case (cmd_r)
         CMD_SET:   match = q & ~qb;
         CMD_RESET: match = ~q & qb;
         default:   match = q ^ qb;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cmd_r  <= CMD_READ;
         cnt    <= 8'd0;
         E      <= 1'b0;
         sr     <= 2'b00;
         done   <= 1'b0;
         status <= ST_OK;
         q_cap  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // rst_n is high in this branch, so cmd_ready == (state == IDLE).
               if (cmd_valid) begin
                  cmd_r <= cmd;
                  cnt   <= 8'd0;
                  if (cmd == CMD_SET || cmd == CMD_RESET) begin
                     E     <= 1'b1;
                     sr    <= cmd;
                     state <= S_PULSE;
                  end else begin
                     // Readback and illegal both take one CHECK edge, which
                     // gives them the same one-edge accept-to-done latency.
                     state <= S_CHECK;
                  end
               end
            end

            S_PULSE: begin
               if (cnt >= PULSE_LAST) begin
                  E     <= 1'b0;
                  sr    <= 2'b00;
                  cnt   <= 8'd0;
                  state <= S_SETTLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            S_SETTLE: begin
               // q/qb are deliberately not looked at here; glitches while the
               // latch is switching are ignored.
               if (cnt >= SETTLE_LAST) begin
                  cnt   <= 8'd0;
                  state <= S_CHECK;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            S_CHECK: begin
               if (cmd_r == CMD_ILL) begin
                  done   <= 1'b1;
                  status <= ST_ILLEGAL;
                  q_cap  <= q;
                  state  <= S_RESP;
               end else if (match) begin
                  done   <= 1'b1;
                  status <= ST_OK;
                  q_cap  <= q;
                  state  <= S_RESP;
               end else if (cnt_inc >= TIMEOUT_LIM) begin
                  // This edge is sample number TIMEOUT_CYC without a match.
                  done   <= 1'b1;
                  status <= ST_TIMEOUT;
                  q_cap  <= q;
                  cnt    <= cnt_inc;
                  state  <= S_RESP;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            S_RESP: begin
               // done was raised on entry; it drops here and the driver
               // becomes ready again on the following cycle.
               cnt   <= 8'd0;
               state <= S_IDLE;
            end

            default: begin
               E     <= 1'b0;
               sr    <= 2'b00;
               cnt   <= 8'd0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Drives sr_latch_driver against a behavioural latch (optionally stuck at
// q=qb=0 / q=qb=1, or glitching while the pulse is in flight) and compares
// each response with a command-level reference model: latency, status, q_cap,
// enable pulse width and the S/R code driven.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

   localparam int P = 2;
   localparam int S = 1;
   localparam int T = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       cmd_ready;
   logic       E;
   logic [1:0] sr;
   logic       q;
   logic       qb;
   logic       done;
   logic [1:0] status;
   logic       q_cap;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   sr_latch_driver #(
      .PULSE_CYC  (P),
      .SETTLE_CYC (S),
      .TIMEOUT_CYC(T)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd      (cmd),
      .E        (E),
      .sr       (sr),
      .q        (q),
      .qb       (qb),
      .done     (done),
      .status   (status),
      .q_cap    (q_cap),
      .dbg_state(dbg_state)
   );

   // ---------------- latch plant ----------------
   // mode: 0 responsive, 1 stuck q=qb=0, 3 stuck q=qb=1
   int   mode = 0;
   logic plant_q = 1'b0;
   logic glitch_on = 1'b0;
   logic glitch_q = 1'b0;
   logic glitch_qb = 1'b0;

   always @(posedge clk) begin
      if (E && sr == 2'b10) plant_q <= 1'b1;
      else if (E && sr == 2'b01) plant_q <= 1'b0;
   end

   always_comb begin
      q  = plant_q;
      qb = ~plant_q;
      if (mode == 1) begin
         q  = 1'b0;
         qb = 1'b0;
      end else if (mode == 3) begin
         q  = 1'b1;
         qb = 1'b1;
      end else if (glitch_on) begin
         q  = glitch_q;
         qb = glitch_qb;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [10:0] exp_q[$];   // {latency[7:0], status[1:0], q_cap}
   bit model_q = 1'b0;      // what the latch should hold after completed writes

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Command-level reference: what the driver must answer and how long it takes.
   function automatic logic [10:0] model_resp(input logic [1:0] c, input int m);
      int         lat;
      logic [1:0] st;
      logic       qc;
      bit         stuck;
      stuck = (m == 1) || (m == 3);
      if (c == 2'b11) begin
         lat = 1; st = 2'b10; qc = 1'b0;
      end else if (c == 2'b00) begin
         if (stuck) begin lat = T; st = 2'b01; qc = (m == 3); end
         else       begin lat = 1; st = 2'b00; qc = model_q; end
      end else begin
         if (stuck) begin lat = P + S + T; st = 2'b01; qc = (m == 3); end
         else       begin lat = P + S + 1; st = 2'b00; qc = (c == 2'b10); end
      end
      return {8'(lat), st, qc};
   endfunction

   // ---------------- driver ----------------
   task automatic run_cmd(input logic [1:0] c, input int m, input bit glitch, input bit noise);
      logic [10:0] e;
      int  waitc, lat, e_cyc, exp_e;
      bit  got_done, sr11, srbad, ready_busy, is_wr;
      is_wr = (c == 2'b01) || (c == 2'b10);
      mode  = m;
      e     = model_resp(c, m);
      exp_q.push_back(e);
      if (is_wr) model_q = (c == 2'b10);
      exp_e = is_wr ? P : 0;

      waitc = 0;
      while (!cmd_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("ready_wait", (waitc < 50), 1);
      cmd       = c;
      cmd_valid = 1'b1;
      @(posedge clk);          // accept edge (edge 0)
      @(negedge clk);

      lat = 0; e_cyc = 0; got_done = 0; sr11 = 0; srbad = 0; ready_busy = 0;
      while (lat < 300) begin
         if (sr == 2'b11) sr11 = 1;
         if (E) begin
            e_cyc++;
            if (sr !== c) srbad = 1;
         end else if (sr !== 2'b00) srbad = 1;
         if (done) begin
            got_done = 1;
            break;
         end
         if (cmd_ready) ready_busy = 1;
         glitch_on = glitch && is_wr && (lat < P + S);
         glitch_q  = 1'($urandom_range(0, 1));
         glitch_qb = 1'($urandom_range(0, 1));
         cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd       = 2'($urandom_range(0, 3));
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      glitch_on = 1'b0;

      e = exp_q.pop_front();
      check("done_seen", got_done, 1);
      if (got_done) begin
         check("latency", lat, 32'(e[10:3]));
         check("status", status, e[2:1]);
         if (c != 2'b11) check("q_cap", q_cap, e[0]);
      end
      check("e_cycles", e_cyc, exp_e);
      check("sr_never_11", sr11, 0);
      check("sr_code", srbad, 0);
      check("ready_low_busy", ready_busy, 0);

      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_after_done", cmd_ready, 1);
      check("status_held", status, e[2:1]);
   endtask

   task automatic mid_pulse_reset();
      int done_cnt;
      mode  = 0;
      cmd   = 2'b10;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("pulse_started", E, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_E", E, 0);
      check("rst_sr", sr, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("no_done_aborted", done_cnt, 0);
      check("ready_after_rst", cmd_ready, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      #12;
      check("reset_E", E, 0);
      check("reset_sr", sr, 0);
      check("reset_done", done, 0);
      check("reset_status", status, 0);
      check("reset_qcap", q_cap, 0);
      check("reset_ready", cmd_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_idle", cmd_ready, 1);

      run_cmd(2'b10, 0, 0, 0);   // set
      run_cmd(2'b01, 0, 0, 0);   // reset after set
      run_cmd(2'b10, 0, 0, 1);   // set with busy noise
      run_cmd(2'b00, 0, 0, 0);   // readback q=1
      run_cmd(2'b11, 0, 0, 1);   // illegal
      run_cmd(2'b10, 1, 0, 0);   // stuck 00 -> timeout
      run_cmd(2'b00, 3, 0, 0);   // stuck 11 readback -> timeout
      run_cmd(2'b01, 0, 1, 0);   // glitches during pulse/settle ignored

      mid_pulse_reset();
      model_q = plant_q;         // aborted write: latch holds whatever it had
      run_cmd(2'b10, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [1:0] c;
         int         m;
         c = 2'($urandom_range(0, 3));
         m = ($urandom_range(0, 9) < 7) ? 0 : (($urandom_range(0, 1) == 1) ? 1 : 3);
         run_cmd(c, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
